bias_z_drain: RTL and testbench

//  Consumer end of the bias stage's Z stream: captures the valid-qualified Q8.8 words
//  a bias column emits, which cannot be stalled. Buffers them in a small FIFO and

---
 rtl/bias_z_drain_if.sv | 30 +++
 rtl/bias_z_drain.sv | 108 ++++++++++
 tb/tb_bias_z_drain.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/bias_z_drain_if.sv
// Handshake bundle between a bias column's Z stream, the tile controller and the
// unified-buffer write port. The slave modport is the drain block itself.
interface bias_z_drain_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16,
   parameter int ROW_W  = 8
);
   logic              start_in;
   logic [ADDR_W-1:0] base_addr_in;
   logic [ROW_W-1:0]  num_rows_in;
   logic [DATA_W-1:0] z_data_in;
   logic              z_valid_in;
   logic [DATA_W-1:0] wr_data_out;
   logic [ADDR_W-1:0] wr_addr_out;
   logic              wr_valid_out;
   logic              wr_ready_in;
   logic              busy_out;
   logic              done_out;
   logic              overflow_out;

   modport master (
      output start_in, base_addr_in, num_rows_in, z_data_in, z_valid_in, wr_ready_in,
      input  wr_data_out, wr_addr_out, wr_valid_out, busy_out, done_out, overflow_out
   );

   modport slave (
      input  start_in, base_addr_in, num_rows_in, z_data_in, z_valid_in, wr_ready_in,
      output wr_data_out, wr_addr_out, wr_valid_out, busy_out, done_out, overflow_out
   );
endinterface

// File: rtl/bias_z_drain.sv
// Captures a non-stallable Z word stream into a small FWFT FIFO and drains it to the
// unified buffer over valid/ready with auto-incrementing addresses, one tile per start.
module bias_z_drain #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 16,
   parameter int ROW_W  = 8
) (
   input logic           clk,
   input logic           rst,
   bias_z_drain_if.slave bus
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int SUM_W = ROW_W + 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t            state_reg, state_next;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
   logic [CNT_W-1:0]  count_reg;
   logic [ADDR_W-1:0] base_addr_reg;
   logic [ROW_W-1:0]  num_rows_reg;
   logic [ROW_W-1:0]  push_cnt_reg, pop_cnt_reg, drop_cnt_reg;
   logic              overflow_reg;

   logic              accept_start, push_req, push, pop, drop, full, wr_valid;
   logic [SUM_W-1:0]  retired_next;

   assign accept_start = (state_reg == IDLE) && bus.start_in;
   assign wr_valid     = (state_reg == RUN) && (count_reg != '0);
   assign pop          = wr_valid && bus.wr_ready_in;
   assign full         = (count_reg == CNT_W'(DEPTH));
   assign push_req     = (state_reg == RUN) && bus.z_valid_in && (push_cnt_reg < num_rows_reg);
   // A full FIFO still accepts the word if a transfer frees a slot on the same edge.
   assign drop         = push_req && full && !pop;
   assign push         = push_req && !drop;

   // Words leave the tile either by transfer or by being dropped; both count toward completion.
   assign retired_next = SUM_W'(pop_cnt_reg) + SUM_W'(drop_cnt_reg) + SUM_W'(pop) + SUM_W'(drop);

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: if (bus.start_in) state_next = (bus.num_rows_in == '0) ? DONE : RUN;
         RUN:  if (retired_next == SUM_W'(num_rows_reg)) state_next = DONE;
         DONE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_reg] <= bus.z_data_in;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= IDLE;
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         count_reg     <= '0;
         base_addr_reg <= '0;
         num_rows_reg  <= '0;
         push_cnt_reg  <= '0;
         pop_cnt_reg   <= '0;
         drop_cnt_reg  <= '0;
         overflow_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (accept_start) begin
            base_addr_reg <= bus.base_addr_in;
            num_rows_reg  <= bus.num_rows_in;
            push_cnt_reg  <= '0;
            pop_cnt_reg   <= '0;
            drop_cnt_reg  <= '0;
            overflow_reg  <= 1'b0;
         end else begin
            if (push) begin
               wr_ptr_reg   <= wr_ptr_reg + PTR_W'(1);
               push_cnt_reg <= push_cnt_reg + ROW_W'(1);
            end
            if (drop) begin
               push_cnt_reg <= push_cnt_reg + ROW_W'(1);
               drop_cnt_reg <= drop_cnt_reg + ROW_W'(1);
               overflow_reg <= 1'b1;
            end
            if (pop) begin
               rd_ptr_reg  <= rd_ptr_reg + PTR_W'(1);
               pop_cnt_reg <= pop_cnt_reg + ROW_W'(1);
            end
            case ({push, pop})
               2'b10:   count_reg <= count_reg + CNT_W'(1);
               2'b01:   count_reg <= count_reg - CNT_W'(1);
               default: count_reg <= count_reg;
            endcase
         end
      end
   end

   // Data is gated so the write port reads as zero whenever no request is pending.
   assign bus.wr_data_out  = wr_valid ? mem[rd_ptr_reg] : '0;
   assign bus.wr_addr_out  = base_addr_reg + ADDR_W'(pop_cnt_reg);
   assign bus.wr_valid_out = wr_valid;
   assign bus.busy_out     = (state_reg == RUN);
   assign bus.done_out     = (state_reg == DONE);
   assign bus.overflow_out = overflow_reg;
endmodule

// File: tb/tb_bias_z_drain.sv
// Directed bench for bias_z_drain: tiles framed by start/done, FIFO full/drop cases,
// stalled write port hold behaviour, address wrap and mid-tile reset.
module tb_bias_z_drain;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   bias_z_drain_if #(.DATA_W(16), .ADDR_W(16), .ROW_W(8)) bus ();

   bias_z_drain #(.DATA_W(16), .DEPTH(8), .ADDR_W(16), .ROW_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int done_cnt = 0;
   int valid_cycles = 0;
   logic [15:0] got_data[$];
   logic [15:0] got_addr[$];
   logic [15:0] exp_data[$];
   logic        prev_stall = 1'b0;
   logic [15:0] prev_data = '0;
   logic [15:0] prev_addr = '0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Write-port monitor, sampled on the falling edge between active edges.
   always @(negedge clk) begin
      if (!rst) begin
         if (prev_stall) begin
            chk("hold_valid", {31'd0, bus.wr_valid_out}, 32'd1);
            chk("hold_data", {16'd0, bus.wr_data_out}, {16'd0, prev_data});
            chk("hold_addr", {16'd0, bus.wr_addr_out}, {16'd0, prev_addr});
         end
         if (bus.wr_valid_out) valid_cycles++;
         if (bus.done_out) done_cnt++;
         if (bus.wr_valid_out && bus.wr_ready_in) begin
            got_data.push_back(bus.wr_data_out);
            got_addr.push_back(bus.wr_addr_out);
            $display("write addr=0x%04h data=0x%04h", bus.wr_addr_out, bus.wr_data_out);
         end
         prev_stall = bus.wr_valid_out && !bus.wr_ready_in;
         prev_data  = bus.wr_data_out;
         prev_addr  = bus.wr_addr_out;
      end else begin
         prev_stall = 1'b0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [15:0] base, input logic [7:0] rows);
      bus.start_in     = 1'b1;
      bus.base_addr_in = base;
      bus.num_rows_in  = rows;
      tick();
      bus.start_in = 1'b0;
   endtask

   task automatic push_word(input logic [15:0] w, input bit kept);
      bus.z_valid_in = 1'b1;
      bus.z_data_in  = w;
      if (kept) exp_data.push_back(w);
      tick();
      bus.z_valid_in = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int limit);
      for (int i = 0; i < limit && bus.done_out !== 1'b1; i++) tick();
      chk({tag, "_done"}, {31'd0, bus.done_out}, 32'd1);
      tick();
      chk({tag, "_pulse"}, {31'd0, bus.done_out}, 32'd0);
   endtask

   task automatic verify(input string tag, input logic [15:0] base);
      logic [15:0] ea;
      chk({tag, "_count"}, got_data.size(), exp_data.size());
      for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
         ea = base + 16'(i);
         chk($sformatf("%s_data%0d", tag, i), {16'd0, got_data[i]}, {16'd0, exp_data[i]});
         chk($sformatf("%s_addr%0d", tag, i), {16'd0, got_addr[i]}, {16'd0, ea});
      end
      got_data.delete();
      got_addr.delete();
      exp_data.delete();
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_valid"}, {31'd0, bus.wr_valid_out}, 32'd0);
      chk({tag, "_data"}, {16'd0, bus.wr_data_out}, 32'd0);
      chk({tag, "_addr"}, {16'd0, bus.wr_addr_out}, 32'd0);
      chk({tag, "_busy"}, {31'd0, bus.busy_out}, 32'd0);
      chk({tag, "_done"}, {31'd0, bus.done_out}, 32'd0);
      chk({tag, "_ovf"}, {31'd0, bus.overflow_out}, 32'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0;
      int v0;
      int pushed;
      logic [15:0] pat;
      bus.start_in     = 1'b0;
      bus.base_addr_in = '0;
      bus.num_rows_in  = '0;
      bus.z_data_in    = '0;
      bus.z_valid_in   = 1'b0;
      bus.wr_ready_in  = 1'b0;

      // Reset state
      repeat (3) tick();
      chk_idle_outputs("rst");
      rst = 1'b0;
      tick();

      // T1: four Q8.8 words, ready high
      bus.wr_ready_in = 1'b1;
      do_start(16'h0100, 8'd4);
      chk("t1_busy", {31'd0, bus.busy_out}, 32'd1);
      push_word(16'h0100, 1'b1);
      push_word(16'h0200, 1'b1);
      push_word(16'hFF00, 1'b1);
      push_word(16'h0080, 1'b1);
      wait_done("t1", 20);
      verify("t1", 16'h0100);

      // T2: ready low, ninth word dropped on full FIFO
      bus.wr_ready_in = 1'b0;
      do_start(16'h0200, 8'd9);
      for (int i = 0; i < 9; i++) push_word(16'h1100 + 16'(i), i < 8);
      chk("t2_ovf", {31'd0, bus.overflow_out}, 32'd1);
      chk("t2_valid", {31'd0, bus.wr_valid_out}, 32'd1);
      bus.wr_ready_in = 1'b1;
      wait_done("t2", 30);
      verify("t2", 16'h0200);
      chk("t2_ovf_sticky", {31'd0, bus.overflow_out}, 32'd1);

      // T3: push and transfer on the same edge while full
      bus.wr_ready_in = 1'b0;
      do_start(16'h0300, 8'd9);
      chk("t3_ovf_clr", {31'd0, bus.overflow_out}, 32'd0);
      for (int i = 0; i < 8; i++) push_word(16'h2200 + 16'(i), 1'b1);
      bus.wr_ready_in = 1'b1;
      push_word(16'h2208, 1'b1);
      chk("t3_ovf", {31'd0, bus.overflow_out}, 32'd0);
      wait_done("t3", 30);
      verify("t3", 16'h0300);

      // T4: empty tile, then start during RUN ignored
      v0 = valid_cycles;
      do_start(16'h0AAA, 8'd0);
      chk("t4_done", {31'd0, bus.done_out}, 32'd1);
      chk("t4_busy", {31'd0, bus.busy_out}, 32'd0);
      tick();
      chk("t4_pulse", {31'd0, bus.done_out}, 32'd0);
      chk("t4_novalid", valid_cycles, v0);
      do_start(16'h0400, 8'd2);
      do_start(16'h0500, 8'd5);
      push_word(16'h3300, 1'b1);
      push_word(16'h3301, 1'b1);
      wait_done("t4b", 20);
      verify("t4b", 16'h0400);

      // T5: toggling ready, 20 rows, address wraps past 0xFFFF
      pat = 16'b1011_0110_1101_0011;
      do_start(16'hFFF8, 8'd20);
      pushed = 0;
      for (int cyc = 0; cyc < 200 && bus.done_out !== 1'b1; cyc++) begin
         bus.wr_ready_in = pat[cyc % 16];
         if ((cyc % 2 == 0) && pushed < 20) begin
            bus.z_valid_in = 1'b1;
            bus.z_data_in  = 16'h1000 + 16'(pushed) * 16'h0101;
            exp_data.push_back(bus.z_data_in);
            pushed++;
         end else begin
            bus.z_valid_in = 1'b0;
         end
         tick();
      end
      bus.z_valid_in = 1'b0;
      chk("t5_done", {31'd0, bus.done_out}, 32'd1);
      chk("t5_ovf", {31'd0, bus.overflow_out}, 32'd0);
      tick();
      verify("t5", 16'hFFF8);

      // T6: reset after two of four writes
      bus.wr_ready_in = 1'b1;
      do_start(16'h0600, 8'd4);
      push_word(16'h4400, 1'b1);
      push_word(16'h4401, 1'b1);
      tick();
      d0 = done_cnt;
      rst = 1'b1;
      #1;
      chk_idle_outputs("t6_rst");
      tick();
      rst = 1'b0;
      repeat (3) tick();
      chk("t6_nodone", done_cnt, d0);
      verify("t6a", 16'h0600);
      do_start(16'h0700, 8'd2);
      push_word(16'h5500, 1'b1);
      push_word(16'h5501, 1'b1);
      wait_done("t6b", 20);
      verify("t6b", 16'h0700);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
